// File: rtl/program_loader_pkg.sv
// Shared loader definitions: FSM state encodings, frame start marker and word geometry.
// Imported by the loader top level and by its byte packer.
package program_loader_pkg;

    localparam logic [7:0] HDR_BYTE_DEF   = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input plus memory write port of the program loader.
// master = stream source / memory side, slave = loader.
interface program_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader_byte_packer.sv
// Packs accepted bytes MSB-first into a word; word_vld/word_dat are combinational on the 4th byte.
// No backpressure of its own: it only advances on bytes the parent has already accepted.
module program_loader_byte_packer
    import program_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    output logic              word_vld,
    output logic [DATA_W-1:0] word_dat
);

    logic [1:0]        cnt;
    logic [DATA_W-9:0] shift;

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            shift <= '0;
        end else if (byte_vld) begin
            cnt   <= cnt + 2'd1;
            shift <= {shift[DATA_W-17:0], byte_dat};
        end
    end

    // The completed word includes the byte arriving this cycle, so the parent can latch it at once.
    assign word_vld = byte_vld && (cnt == 2'(BYTES_PER_WORD - 1));
    assign word_dat = {shift, byte_dat};

endmodule

// File: rtl/program_loader.sv
// Boot loader: framed byte stream -> 32-bit memory writes; mem_we one cycle after the 4th byte.
// in_ready drops only during the WRITE cycle; optional checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         ADDR_W   = 8,
    parameter int         DATA_W   = 32,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input  logic             clk1,
    input  logic             reset,
    program_loader_if.slave  bus,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_err
);

    localparam int CNT_W = ADDR_W + 1;

    state_t            state, state_nxt;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  words_left;
    logic              cpu_reset_q;
    logic              done_q;
    logic              hs;
    logic              is_hdr;
    logic              last_word;
    logic              word_vld;
    logic [DATA_W-1:0] word_dat;

    assign hs        = bus.in_valid && in_ready_q;
    assign is_hdr    = (bus.in_data == HDR_BYTE);
    assign last_word = (words_left == CNT_W'(1));

    program_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk1     (clk1),
        .reset    (reset),
        .byte_vld (hs && (state == S_DATA)),
        .byte_dat (bus.in_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state_nxt == S_ERR);
            if (state_nxt == S_LEN)
                csum <= '0;
            else if (hs && (state == S_DATA))
                csum <= csum ^ bus.in_data;
        end
    end

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hs && is_hdr) state_nxt = S_LEN;
            S_LEN:   if (hs) state_nxt = S_ADDR;
            S_ADDR:  if (hs) state_nxt = S_DATA;
            S_DATA:  if (word_vld) state_nxt = S_WRITE;
            S_WRITE: begin
                if (!last_word)
                    state_nxt = S_DATA;
                else
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:  if (hs) state_nxt = (bus.in_data == csum) ? S_DONE : S_ERR;
`endif
            S_DONE, S_ERR: if (hs && is_hdr) state_nxt = S_LEN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            words_left  <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != S_WRITE);
            mem_we_q    <= (state_nxt == S_WRITE);
            cpu_reset_q <= (state_nxt != S_DONE);
            done_q      <= (state_nxt == S_DONE);
            if (hs && (state == S_LEN))
                words_left <= (bus.in_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : CNT_W'(bus.in_data);
            if (hs && (state == S_ADDR))
                addr_q <= ADDR_W'(bus.in_data);
            if (state == S_WRITE) begin
                words_left <= words_left - CNT_W'(1);
                addr_q     <= addr_q + ADDR_W'(1);
            end
            if (word_vld)
                wdata_q <= word_dat;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign load_done     = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed table of frames with expected writes/status, plus mid-frame reset and reload sequences.
module tb_program_loader;

    logic clk1  = 1'b0;
    logic reset = 1'b0;
    logic cpu_reset, load_done, load_err;

    program_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    program_loader dut (
        .clk1      (clk1),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [127:0] bytes;
        int           nb;
        int           nw;
        logic [7:0]   a [3];
        logic [31:0]  d [3];
        logic         done;
        logic         err;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    int          rdy_low;
    int          overlap;
    logic [7:0]  wa [$];
    logic [31:0] wd [$];
    vec_t        vt [$];

    always @(negedge clk1) begin
        if (mon_en) begin
            if (bus.mem_we) begin
                wa.push_back(bus.mem_addr);
                wd.push_back(bus.mem_wdata);
            end
            if (!bus.in_ready) rdy_low++;
            if (bus.in_ready == bus.mem_we) overlap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [127:0] by, input int nb, input int nw,
                                input logic [7:0] a0, input logic [31:0] d0,
                                input logic [7:0] a1, input logic [31:0] d1,
                                input logic [7:0] a2, input logic [31:0] d2,
                                input logic done, input logic err);
        vec_t v;
        v.bytes = by; v.nb = nb; v.nw = nw;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        v.done = done; v.err = err;
        return v;
    endfunction

    // Holds in_valid high; waits out in_ready=0 cycles, returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk1);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        end
        @(negedge clk1);
    endtask

    task automatic start_mon();
        wa.delete();
        wd.delete();
        rdy_low = 0;
        overlap = 0;
        mon_en  = 1'b1;
    endtask

    task automatic end_frame();
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk1);
        mon_en = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int nw, input vec_t v);
        check($sformatf("%s_nwrites", tag), wa.size(), nw);
        for (int k = 0; k < nw; k++) begin
            if (k < wa.size()) begin
                check($sformatf("%s_addr%0d", tag, k), wa[k], v.a[k]);
                check($sformatf("%s_data%0d", tag, k), wd[k], v.d[k]);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        start_mon();
        for (int k = 0; k < v.nb; k++)
            send_byte(v.bytes[8*(v.nb-1-k) +: 8]);
        end_frame();
        check_writes(tag, v.nw, v);
        check({tag, "_done"}, load_done, v.done);
        check({tag, "_err"}, load_err, v.err);
        check({tag, "_cpu_reset"}, cpu_reset, !v.done);
        check({tag, "_ready_low_cycles"}, rdy_low, v.nw);
        check({tag, "_ready_vs_we"}, overlap, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  bus.in_ready, 0);
        check({tag, "_mem_we"},    bus.mem_we, 0);
        check({tag, "_mem_addr"},  bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"},  load_err, 0);
    endtask

    initial begin
        vec_t v;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

`ifdef LOADER_CHECKSUM_EN
        vt.push_back(mk(128'hA50110DEADBEEF22, 8, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(128'h00FFA502FE112233445566778888, 14, 2, 8'hFE, 32'h11223344,
                        8'hFF, 32'h55667788, 0, 0, 1, 0));
        vt.push_back(mk(128'hA50320010203040A0B0C0DCAFEF00DCD, 16, 3, 8'h20, 32'h01020304,
                        8'h21, 32'h0A0B0C0D, 8'h22, 32'hCAFEF00D, 1, 0));
        vt.push_back(mk(128'h5AA501FF0000000101, 9, 1, 8'hFF, 32'h00000001, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(128'hA501001234567808, 8, 1, 8'h00, 32'h12345678, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(128'hA501001234567809, 8, 1, 8'h00, 32'h12345678, 0, 0, 0, 0, 0, 1));
        vt.push_back(mk(128'hA50130_0000FFFF_00, 8, 1, 8'h30, 32'h0000FFFF, 0, 0, 0, 0, 1, 0));
`else
        vt.push_back(mk(128'hA50110DEADBEEF, 7, 1, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0));
        vt.push_back(mk(128'h00FFA502FE1122334455667788, 13, 2, 8'hFE, 32'h11223344,
                        8'hFF, 32'h55667788, 0, 0, 1, 0));
        vt.push_back(mk(128'hA50320010203040A0B0C0DCAFEF00D, 15, 3, 8'h20, 32'h01020304,
                        8'h21, 32'h0A0B0C0D, 8'h22, 32'hCAFEF00D, 1, 0));
        vt.push_back(mk(128'h5AA501FF00000001, 8, 1, 8'hFF, 32'h00000001, 0, 0, 0, 0, 1, 0));
        // Trailing 09 arrives in DONE and must be dropped.
        vt.push_back(mk(128'hA501001234567809, 8, 1, 8'h00, 32'h12345678, 0, 0, 0, 0, 1, 0));
`endif

        repeat (3) @(negedge clk1);
        check_reset_vals("por");
        reset = 1'b1;
        repeat (2) @(negedge clk1);

        for (int i = 0; i < vt.size(); i++)
            run_vec(vt[i], i);

        // Reset asserted after the second data byte of a frame.
        start_mon();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h40);
        send_byte(8'hAA); send_byte(8'hBB);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk1);
        mon_en = 1'b0;
        check("midrst_nwrites", wa.size(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk1);
`ifdef LOADER_CHECKSUM_EN
        v = mk(128'hA501401122334444, 8, 1, 8'h40, 32'h11223344, 0, 0, 0, 0, 1, 0);
`else
        v = mk(128'hA5014011223344, 7, 1, 8'h40, 32'h11223344, 0, 0, 0, 0, 1, 0);
`endif
        run_vec(v, 100);

        // Reload from DONE: header alone must re-assert cpu_reset and clear load_done.
        start_mon();
        send_byte(8'hA5);
        check("reload_hdr_cpu_reset", cpu_reset, 1);
        check("reload_hdr_load_done", load_done, 0);
        send_byte(8'h01); send_byte(8'h50);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h30);
`endif
        end_frame();
        v = mk(128'h0, 0, 1, 8'h50, 32'hCAFEBABE, 0, 0, 0, 0, 1, 0);
        check_writes("reload", 1, v);
        check("reload_load_done", load_done, 1);
        check("reload_cpu_reset", cpu_reset, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
